// File: rtl/dds_reg_writer.sv
// dds_reg_writer: frames one DDS register access as an instruction byte plus 1..4 data bytes on a byte-wide SPI engine.
// Latency: 1+CS_SETUP+sum(1+wait_i)+CS_HOLD cycles from accept to IDLE, plus IOUPD_CYCLES for writes.
// Backpressure: cmd_ready only in IDLE (no queuing); each byte waits on spi_done, bounded by a TIMEOUT watchdog.
module dds_reg_writer #(
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int IOUPD_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [4:0]  cmd_addr,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic [7:0]  spi_din,
  output logic        spi_start,
  input  logic        spi_done,
  input  logic [7:0]  spi_dout,
  output logic        CS_N,
  output logic        IO_UPDATE,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_HOLD, S_IOUPD
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_rd;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_len;
  logic [2:0]  r_idx;       // index of the byte in flight: 0 = instruction, 1..len = data
  logic [15:0] r_cnt;       // cycles spent in the current state
  logic [12:0] r_wdog;      // cycles spent in WAIT for the current byte
  logic [7:0]  r_din;
  logic [31:0] r_rd_data;

  logic        w_accept;
  logic        w_setup_done;
  logic        w_hold_done;
  logic        w_ioupd_done;
  logic        w_byte_done;
  logic        w_timeout;
  logic        w_more;
  logic [2:0]  w_len;
  logic [2:0]  w_next_idx;
  logic [2:0]  w_sel;
  logic [7:0]  w_data_byte;

  assign w_accept     = (r_state == S_IDLE) && cmd_valid;
  assign w_setup_done = (r_cnt == 16'(CS_SETUP - 1));
  assign w_hold_done  = (r_cnt == 16'(CS_HOLD - 1));
  assign w_ioupd_done = (r_cnt == 16'(IOUPD_CYCLES - 1));
  // The first WAIT cycle (watchdog still 0) ignores spi_done so a lagging engine cannot complete a byte early.
  assign w_byte_done  = (r_state == S_WAIT) && (r_wdog != 13'd0) && spi_done;
  assign w_timeout    = (r_state == S_WAIT) && !w_byte_done && (r_wdog == 13'(TIMEOUT - 1));
  assign w_more       = (r_idx < r_len);
  assign w_len        = (cmd_len == 3'd0) ? 3'd1 : (cmd_len > 3'd4) ? 3'd4 : cmd_len;
  assign w_next_idx   = r_idx + 3'd1;
  assign w_sel        = r_len - w_next_idx;

  // Data bytes go out MSB first from the right-aligned word: byte k is word byte (len-k).
  always_comb begin
    case (w_sel)
      3'd0:    w_data_byte = r_data[7:0];
      3'd1:    w_data_byte = r_data[15:8];
      3'd2:    w_data_byte = r_data[23:16];
      default: w_data_byte = r_data[31:24];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a watchdog expiry drops straight back to IDLE, skipping HOLD and IOUPD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_SETUP;
      S_SETUP: if (w_setup_done) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (w_byte_done)    w_next = w_more ? S_START : S_HOLD;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_HOLD:  if (w_hold_done) w_next = r_rd ? S_IDLE : S_IOUPD;
      S_IOUPD: if (w_ioupd_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, per-state counter, byte sequencing, watchdog and read shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd      <= 1'b0;
      r_addr    <= 5'd0;
      r_data    <= 32'd0;
      r_len     <= 3'd1;
      r_idx     <= 3'd0;
      r_cnt     <= 16'd0;
      r_wdog    <= 13'd0;
      r_din     <= 8'd0;
      r_rd_data <= 32'd0;
    end else begin
      r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (w_accept) begin
        r_rd      <= cmd_rd;
        r_addr    <= cmd_addr;
        r_data    <= cmd_data;
        r_len     <= w_len;
        r_idx     <= 3'd0;
        r_rd_data <= 32'd0;
      end
      // spi_din is loaded on the edge into START so it is stable for the whole byte.
      if (r_state == S_SETUP && w_setup_done)
        r_din <= {r_rd, 2'b00, r_addr};
      // Watchdog restarts in START, so every byte gets a full TIMEOUT budget.
      if (r_state == S_START)
        r_wdog <= 13'd0;
      else if (r_state == S_WAIT)
        r_wdog <= r_wdog + 13'd1;
      if (w_byte_done) begin
        if (r_rd && r_idx != 3'd0)
          r_rd_data <= {r_rd_data[23:0], spi_dout};
        if (w_more) begin
          r_idx <= w_next_idx;
          r_din <= w_data_byte;
        end
      end
    end
  end

  // Outputs decoded from state; rd_valid and err are single-cycle strobes on the exit transitions.
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    CS_N      = !(r_state == S_SETUP || r_state == S_START ||
                  r_state == S_WAIT  || r_state == S_HOLD);
    spi_start = (r_state == S_START);
    IO_UPDATE = (r_state == S_IOUPD);
    rd_valid  = (r_state == S_HOLD) && w_hold_done && r_rd;
    err       = w_timeout;
    spi_din   = r_din;
    rd_data   = r_rd_data;
  end

endmodule

// File: tb/tb_dds_reg_writer.sv
// tb_dds_reg_writer: directed commands against an SPI byte-engine model with a queue-based scoreboard.
// Expected bytes, read words, IO_UPDATE widths, err distances, latencies and start counts are queued by the driver.
// A negedge monitor pops and compares whenever the DUT presents the corresponding event.
module tb_dds_reg_writer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [4:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_data;
  logic [7:0]  spi_din;
  logic        spi_start;
  logic        spi_done;
  logic [7:0]  spi_dout;
  logic        CS_N;
  logic        IO_UPDATE;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        err;
  logic        busy;

  dds_reg_writer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .spi_din(spi_din), .spi_start(spi_start), .spi_done(spi_done), .spi_dout(spi_dout),
    .CS_N(CS_N), .IO_UPDATE(IO_UPDATE), .rd_data(rd_data), .rd_valid(rd_valid),
    .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_din[$];
  logic [31:0] exp_rd[$];
  int          exp_io[$];
  int          exp_err[$];
  int          exp_lat[$];
  int          exp_ns[$];
  logic [7:0]  ret_q[$];

  int m_lag   = 0;
  int m_delay = 20;
  bit m_hang  = 1'b0;
  int n_start = 0;

  // SPI byte engine: on a start, optionally keep done high for m_lag cycles, then low for m_delay cycles.
  initial begin
    spi_done = 1'b1;
    spi_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        for (int i = 0; i < m_lag; i++) @(negedge clk);
        spi_done = 1'b0;
        if (m_hang) begin
          while (m_hang) @(negedge clk);
        end else begin
          for (int j = 0; j < m_delay; j++) @(negedge clk);
        end
        spi_dout = (ret_q.size() > 0) ? ret_q.pop_front() : 8'h00;
        spi_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    bit prev_rst   = 1'b0;
    bit prev_busy  = 1'b0;
    bit prev_start = 1'b0;
    bit prev_io    = 1'b0;
    int io_w       = 0;
    int acc_cyc    = 0;
    int acc_start  = 0;
    int last_start = 0;
    int e;
    forever begin
      @(negedge clk);
      #2;
      if (prev_rst) begin
        checks++;
        if ({CS_N, spi_start, spi_din, IO_UPDATE, rd_data, rd_valid, err, busy, cmd_ready} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL reset_state got cs_n=%b start=%b din=%h ioupd=%b rd_data=%h rd_valid=%b err=%b busy=%b ready=%b want 1 0 00 0 00000000 0 0 0 1",
                   CS_N, spi_start, spi_din, IO_UPDATE, rd_data, rd_valid, err, busy, cmd_ready);
        end
      end
      if (cmd_valid && cmd_ready && !rst) begin
        acc_cyc   = cyc;
        acc_start = n_start;
      end
      if (spi_start) begin
        n_start++;
        checks++;
        if (CS_N !== 1'b0 || prev_start) begin
          errors++;
          $display("FAIL start_framing got cs_n=%b prev_start=%b want 0 0", CS_N, prev_start);
        end
        checks++;
        if (exp_din.size() == 0) begin
          errors++;
          $display("FAIL spi_din unexpected start with din=%h", spi_din);
        end else begin
          logic [7:0] eb;
          eb = exp_din.pop_front();
          if (spi_din !== eb) begin
            errors++;
            $display("FAIL spi_din got=%h want=%h", spi_din, eb);
          end
        end
        last_start = cyc;
      end
      if (rd_valid) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_valid unexpected rd_data=%h", rd_data);
        end else begin
          logic [31:0] ew;
          ew = exp_rd.pop_front();
          if (rd_data !== ew) begin
            errors++;
            $display("FAIL rd_data got=%h want=%h", rd_data, ew);
          end
        end
      end
      if (err) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("FAIL err unexpected pulse at cycle %0d", cyc);
        end else begin
          e = exp_err.pop_front();
          if (cyc - last_start != e) begin
            errors++;
            $display("FAIL err_delay got=%0d want=%0d", cyc - last_start, e);
          end
        end
      end
      if (IO_UPDATE) begin
        if (!prev_io) begin
          checks++;
          if (CS_N !== 1'b1) begin
            errors++;
            $display("FAIL ioupd_cs got cs_n=%b want 1", CS_N);
          end
        end
        io_w++;
      end else if (prev_io) begin
        checks++;
        if (exp_io.size() == 0) begin
          errors++;
          $display("FAIL io_update unexpected pulse width=%0d", io_w);
        end else begin
          e = exp_io.pop_front();
          if (io_w != e) begin
            errors++;
            $display("FAIL io_update_width got=%0d want=%0d", io_w, e);
          end
        end
        io_w = 0;
      end
      if (!busy && prev_busy && !prev_rst) begin
        checks++;
        if (CS_N !== 1'b1) begin
          errors++;
          $display("FAIL idle_cs got cs_n=%b want 1", CS_N);
        end
        checks++;
        if (exp_lat.size() == 0) begin
          errors++;
          $display("FAIL latency unexpected command end got=%0d", cyc - acc_cyc);
        end else begin
          e = exp_lat.pop_front();
          if (cyc - acc_cyc != e) begin
            errors++;
            $display("FAIL latency got=%0d want=%0d", cyc - acc_cyc, e);
          end
        end
        checks++;
        if (exp_ns.size() == 0) begin
          errors++;
          $display("FAIL start_count unexpected got=%0d", n_start - acc_start);
        end else begin
          e = exp_ns.pop_front();
          if (n_start - acc_start != e) begin
            errors++;
            $display("FAIL start_count got=%0d want=%0d", n_start - acc_start, e);
          end
        end
      end
      prev_rst   = rst;
      prev_busy  = busy;
      prev_start = spi_start;
      prev_io    = IO_UPDATE;
    end
  end

  // Present one command at a negedge and wait (bounded) for the block to return to IDLE.
  task automatic issue(input logic rd, input logic [4:0] a, input logic [2:0] l,
                       input logic [31:0] d, input bit hold);
    int n;
    cmd_rd    = rd;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept got busy=%b want 1", busy);
    end
    n = 0;
    while (busy !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    if (n >= 6000) begin
      errors++;
      $display("FAIL idle_timeout busy still %b after %0d cycles", busy, n);
    end
  endtask

  initial begin : main
    int n;
    int base;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_addr  = 5'd0;
    cmd_len   = 3'd0;
    cmd_data  = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write 0x0E, len 4: 5 bytes of 1+20 cycles each -> 1+2+105+2+4 = 114.
    m_delay = 20;
    exp_din.push_back(8'h0E); exp_din.push_back(8'h12); exp_din.push_back(8'h34);
    exp_din.push_back(8'h56); exp_din.push_back(8'h78);
    exp_io.push_back(4); exp_lat.push_back(114); exp_ns.push_back(5);
    issue(1'b0, 5'h0E, 3'd4, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);

    // Read 0x01, len 2: instruction 0x81; engine answers 0x55 (dropped), 0xAB, 0xCD; 1+2+3*6+2 = 23.
    m_delay = 5;
    ret_q.push_back(8'h55); ret_q.push_back(8'hAB); ret_q.push_back(8'hCD);
    exp_din.push_back(8'h81); exp_din.push_back(8'h00); exp_din.push_back(8'h00);
    exp_rd.push_back(32'h0000_ABCD); exp_lat.push_back(23); exp_ns.push_back(3);
    issue(1'b1, 5'h01, 3'd2, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    // Engine hangs: err 4096 cycles after START, IDLE at 1+2+1+4096 = 4100.
    m_hang = 1'b1;
    exp_din.push_back(8'h02); exp_err.push_back(4096); exp_lat.push_back(4100); exp_ns.push_back(1);
    issue(1'b0, 5'h02, 3'd1, 32'h0000_00AA, 1'b0);
    m_hang = 1'b0;
    repeat (3) @(negedge clk);

    // Following command accepted normally: len 2, delay 3 -> 1+2+3*4+2+4 = 21.
    m_delay = 3;
    exp_din.push_back(8'h06); exp_din.push_back(8'hBE); exp_din.push_back(8'hEF);
    exp_io.push_back(4); exp_lat.push_back(21); exp_ns.push_back(3);
    issue(1'b0, 5'h06, 3'd2, 32'h0000_BEEF, 1'b0);
    repeat (2) @(negedge clk);

    // Reset while waiting on byte 2: only three bytes start, no IO_UPDATE, no err.
    m_delay = 10;
    exp_din.push_back(8'h03); exp_din.push_back(8'h01); exp_din.push_back(8'h02);
    base      = n_start;
    cmd_rd    = 1'b0;
    cmd_addr  = 5'h03;
    cmd_len   = 3'd4;
    cmd_data  = 32'h0102_0304;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (n_start < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL rst_test_wait got starts=%0d want %0d", n_start - base, 3);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // len 0 is treated as 1: instruction + one data byte; 1+2+2*4+2+4 = 17.
    m_delay = 3;
    exp_din.push_back(8'h04); exp_din.push_back(8'hAB);
    exp_io.push_back(4); exp_lat.push_back(17); exp_ns.push_back(2);
    issue(1'b0, 5'h04, 3'd0, 32'h0000_00AB, 1'b0);
    repeat (2) @(negedge clk);

    // len 7 is treated as 4, with cmd_valid held high throughout: 1+2+5*4+2+4 = 29, single accept.
    exp_din.push_back(8'h05); exp_din.push_back(8'h11); exp_din.push_back(8'h22);
    exp_din.push_back(8'h33); exp_din.push_back(8'h44);
    exp_io.push_back(4); exp_lat.push_back(29); exp_ns.push_back(5);
    issue(1'b0, 5'h05, 3'd7, 32'h1122_3344, 1'b1);
    repeat (2) @(negedge clk);

    // Lagging engine: done stays high 2 cycles after start, then low 4 -> 6 WAIT cycles/byte; 1+2+4*7+2 = 33.
    m_lag   = 2;
    m_delay = 4;
    ret_q.push_back(8'h99); ret_q.push_back(8'hDE); ret_q.push_back(8'hAD); ret_q.push_back(8'hBE);
    exp_din.push_back(8'h9F); exp_din.push_back(8'h00); exp_din.push_back(8'h00); exp_din.push_back(8'h00);
    exp_rd.push_back(32'h00DE_ADBE); exp_lat.push_back(33); exp_ns.push_back(4);
    issue(1'b1, 5'h1F, 3'd3, 32'h0, 1'b0);
    repeat (12) @(negedge clk);

    // Every queued expectation must have been consumed.
    checks++;
    if (exp_din.size() != 0) begin errors++; $display("FAIL leftover_din got=%0d want 0", exp_din.size()); end
    checks++;
    if (exp_rd.size() != 0) begin errors++; $display("FAIL leftover_rd got=%0d want 0", exp_rd.size()); end
    checks++;
    if (exp_io.size() != 0) begin errors++; $display("FAIL leftover_io got=%0d want 0", exp_io.size()); end
    checks++;
    if (exp_err.size() != 0) begin errors++; $display("FAIL leftover_err got=%0d want 0", exp_err.size()); end
    checks++;
    if (exp_lat.size() != 0) begin errors++; $display("FAIL leftover_lat got=%0d want 0", exp_lat.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_reg_writer.md
DDS_REG_WRITER -- requirements
Module: dds_reg_writer

Interface
REQ-001 Parameter CS_SETUP, default 2: clk cycles from CS_N falling to the first spi_start.
REQ-002 Parameter CS_HOLD, default 2: clk cycles from the last byte completing to CS_N rising.
REQ-003 Parameter IOUPD_CYCLES, default 4: width of the IO_UPDATE pulse in clk cycles.
REQ-004 Parameter TIMEOUT, default 4096: maximum clk cycles spent waiting for one byte.
REQ-005 Port clk  in  1  system clock; every register updates on its rising edge.
REQ-006 Port rst  in  1  reset; one clock, synchronous, active-high.
REQ-007 Port cmd_valid  in  1  command request.
REQ-008 Port cmd_ready  out  1  high only in IDLE.
REQ-009 Port cmd_rd  in  1  1 = register read, 0 = register write.
REQ-010 Port cmd_addr  in  5  DDS register address.
REQ-011 Port cmd_len  in  3  number of data bytes, legal values 1..4.
REQ-012 Port cmd_data  in  32  write data, right-aligned; ignored for reads.
REQ-013 Port spi_din  out  8  byte presented to the SPI byte engine.
REQ-014 Port spi_start  out  1  one-cycle start pulse to the SPI byte engine.
REQ-015 Port spi_done  in  1  engine idle flag; low while a byte is in flight.
REQ-016 Port spi_dout  in  8  byte received by the SPI byte engine.
REQ-017 Port CS_N  out  1  DDS chip select, active-low.
REQ-018 Port IO_UPDATE  out  1  DDS register-transfer strobe.
REQ-019 Port rd_data  out  32  read result, right-aligned.
REQ-020 Port rd_valid  out  1  one-cycle strobe marking rd_data valid.
REQ-021 Port err  out  1  one-cycle strobe marking a timeout abort.
REQ-022 Port busy  out  1  high whenever the state is not IDLE.

Function
REQ-023 The FSM SHALL have the states IDLE, SETUP, START, WAIT, HOLD, IOUPD.
REQ-024 A command SHALL be accepted in cycle N when cmd_valid and cmd_ready are both high in IDLE.
- At accept the block latches rd, addr, data and len.
- A len of 0 SHALL be latched as 1; a len above 4 SHALL be latched as 4.
REQ-025 CS_N SHALL go low at N+1, with the FSM in SETUP, and stay low through HOLD.
REQ-026 After CS_SETUP cycles in SETUP, the FSM SHALL enter START.
REQ-027 START SHALL last exactly one cycle with spi_start=1, and spi_din stable from that cycle until the byte completes.
REQ-028 Byte 0 SHALL be the instruction byte {rd,2'b00,addr}.
REQ-029 Data byte k (k=1..len) SHALL be data[8*(len-k+1)-1 -: 8], i.e. MSB first.
REQ-030 WAIT SHALL ignore spi_done in its first cycle, then complete the byte on the first cycle with spi_done=1.
REQ-031 On byte completion: if more bytes remain the FSM SHALL go to START; otherwise it SHALL go to HOLD.
REQ-032 For reads, each data-byte completion SHALL shift rd_data <= {rd_data[23:0],spi_dout}.
- rd_data SHALL clear to 0 at accept.
- The instruction byte SHALL NOT be shifted in.
REQ-033 HOLD SHALL last CS_HOLD cycles, after which CS_N SHALL return to 1.
REQ-034 On HOLD exit for a write, the FSM SHALL enter IOUPD with IO_UPDATE=1 for IOUPD_CYCLES cycles, then return to IDLE.
REQ-035 On HOLD exit for a read, rd_valid SHALL pulse for one cycle and the FSM SHALL return to IDLE; IO_UPDATE stays 0.
REQ-036 A 13-bit watchdog SHALL count cycles in WAIT.
- It reloads on every entry to START.
- When it reaches TIMEOUT-1 without a completion, the block SHALL raise err for one cycle, set CS_N=1, skip IOUPD and rd_valid, and return to IDLE.
REQ-037 cmd_valid in any non-IDLE state SHALL be ignored; no queuing.
REQ-038 spi_start SHALL never assert while CS_N=1, nor on two consecutive cycles.
REQ-039 Total write latency from accept to IDLE SHALL be 1+CS_SETUP+sum(1+wait_i)+CS_HOLD+IOUPD_CYCLES cycles.

Reset
REQ-040 With rst high at a clk edge, the block SHALL enter IDLE on the next cycle with these values:
- CS_N=1, spi_start=0, spi_din=0, IO_UPDATE=0
- rd_data=0, rd_valid=0, err=0, busy=0, cmd_ready=1
REQ-041 rst mid-transfer SHALL abort immediately with CS_N=1 and no rd_valid, IO_UPDATE or err.

Verification
REQ-042 Write, addr=0x0E, len=4, data=0x12345678, with an engine model of 20-cycle done-low → spi_din sequence 0x0E,0x12,0x34,0x56,0x78, 5 start pulses, then one IO_UPDATE pulse of 4 cycles after CS_N rises.
REQ-043 Read, addr=0x01, len=2, model returning 0xAB then 0xCD → instruction byte 0x81, rd_data=0x0000ABCD with rd_valid for 1 cycle, IO_UPDATE never high.
REQ-044 Model holding spi_done low forever → err pulse 4096 cycles after START, CS_N=1, then a new command is accepted normally.
REQ-045 rst asserted in WAIT of byte 2 → next cycle CS_N=1, busy=0, no IO_UPDATE.
REQ-046 cmd_len=0 then cmd_len=7 → exactly 2 and 5 start pulses respectively; cmd_valid held high during busy → no second accept until IDLE.
REQ-047 spi_done still high in the cycle after START (lagging engine) → byte not completed early; the FSM waits for the done-low/high cycle.
